// File: rtl/timer_bus_arb.sv
// Round-robin arbiter sharing the timer's single register port between two masters.
// Writes pulse t_ld for one cycle; reads hold t_oe for RD_LAT+1 cycles, then ack with data.
module timer_bus_arb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] t_addr,
   output logic [DATA_W-1:0] t_din,
   output logic              t_ld,
   output logic              t_oe,
   input  logic [DATA_W-1:0] t_dout
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   state_t            state, state_nxt;
   logic              owner_q, we_q, ptr_q, mask_vld_q, mask_idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              eff0, eff1, grant_idx;

   // The master served last is ignored for one IDLE cycle so it can drop req.
   always_comb begin
      eff0      = req0 && !(mask_vld_q && !mask_idx_q);
      eff1      = req1 && !(mask_vld_q && mask_idx_q);
      grant_idx = (eff0 && eff1) ? ptr_q : eff1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (eff0 || eff1) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = we_q ? S_ACK : S_WAIT;
         S_WAIT:  if (cnt_q == '0) state_nxt = S_ACK;
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request latch, read-latency counter, read capture, pointer and post-ack mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         ptr_q      <= 1'b0;
         mask_vld_q <= 1'b0;
         mask_idx_q <= 1'b0;
         rdata      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               mask_vld_q <= 1'b0;
               if (eff0 || eff1) begin
                  owner_q <= grant_idx;
                  we_q    <= grant_idx ? we1    : we0;
                  addr_q  <= grant_idx ? addr1  : addr0;
                  wdata_q <= grant_idx ? wdata1 : wdata0;
               end
            end
            S_ISSUE: cnt_q <= CNT_W'(RD_LAT - 1);
            S_WAIT: begin
               if (cnt_q == '0) rdata <= t_dout;
               else             cnt_q <= cnt_q - 1'b1;
            end
            S_ACK: begin
               ptr_q      <= ~owner_q;
               mask_vld_q <= 1'b1;
               mask_idx_q <= owner_q;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode only registered state, so nothing reaches them from req*.
   always_comb begin
      busy   = (state != S_IDLE);
      gnt0   = busy && !owner_q;
      gnt1   = busy && owner_q;
      ack0   = (state == S_ACK) && !owner_q;
      ack1   = (state == S_ACK) && owner_q;
      t_ld   = (state == S_ISSUE) && we_q;
      t_oe   = ((state == S_ISSUE) && !we_q) || (state == S_WAIT);
      t_addr = busy ? addr_q  : '0;
      t_din  = busy ? wdata_q : '0;
   end

endmodule

// File: tb/tb_timer_bus_arb.sv
// Self-checking bench for timer_bus_arb: a RD_LAT=1 instance plus a RD_LAT=3 instance,
// with expected acks queued when requests are driven and popped when acks appear.
module tb_timer_bus_arb;

   localparam int RD3 = 3;

   typedef struct packed {
      logic        idx;
      logic        we;
      logic [31:0] rdata;
   } exp_t;

   logic        clk, rst;
   logic        req0, we0, req1, we1;
   logic [2:0]  addr0, addr1, t_addr;
   logic [31:0] wdata0, wdata1, t_dout, rdata, t_din;
   logic        gnt0, ack0, gnt1, ack1, busy, t_ld, t_oe;

   logic        req0_b, we0_b, req1_b, we1_b;
   logic [2:0]  addr0_b, addr1_b, t_addr_b;
   logic [31:0] wdata0_b, wdata1_b, t_dout_b, rdata_b, t_din_b;
   logic        gnt0_b, ack0_b, gnt1_b, ack1_b, busy_b, t_ld_b, t_oe_b;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   timer_bus_arb #(.DATA_W(32), .ADDR_W(3), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .ack1(ack1),
      .rdata(rdata), .busy(busy), .t_addr(t_addr), .t_din(t_din),
      .t_ld(t_ld), .t_oe(t_oe), .t_dout(t_dout)
   );

   timer_bus_arb #(.DATA_W(32), .ADDR_W(3), .RD_LAT(RD3)) dut3 (
      .clk(clk), .rst(rst),
      .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .gnt0(gnt0_b), .ack0(ack0_b),
      .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .gnt1(gnt1_b), .ack1(ack1_b),
      .rdata(rdata_b), .busy(busy_b), .t_addr(t_addr_b), .t_din(t_din_b),
      .t_ld(t_ld_b), .t_oe(t_oe_b), .t_dout(t_dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      compared++;
      if ({busy, gnt0, gnt1, ack0, ack1, t_ld, t_oe, t_addr, t_din, rdata} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got busy=%b gnt=%b%b ack=%b%b ld=%b oe=%b rdata=%h, expected all 0",
                  busy, gnt1, gnt0, ack1, ack0, t_ld, t_oe, rdata);
      end
      compared++;
      if ({busy_b, t_ld_b, t_oe_b, rdata_b} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs_rd3: got busy=%b ld=%b oe=%b rdata=%h, expected 0", busy_b, t_ld_b, t_oe_b, rdata_b);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int   ld_cnt = 0;
      int   ack_at = -1;
      logic gnt1_seen = 1'b0;
      exp_t e;
      sb.push_back('{1'b0, 1'b1, 32'h0});
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; wdata0 = 32'h0000_00FF;
      for (int c = 1; c <= 8; c++) begin
         tick();
         gnt1_seen |= gnt1;
         if (t_ld) begin
            ld_cnt++;
            compared++;
            if ({t_addr, t_din} !== {3'd2, 32'h0000_00FF}) begin
               mismatched++;
               $display("[TB] FAIL write_port: got addr=%0d din=%h, expected addr=2 din=000000ff", t_addr, t_din);
            end
         end
         if ((ack0 || ack1) && ack_at < 0) begin
            ack_at = c;
            req0 = 1'b0;
            e = sb.pop_front();
            compared++;
            if ({ack1, ack0} !== (e.idx ? 2'b10 : 2'b01)) begin
               mismatched++;
               $display("[TB] FAIL write_ack_owner: got ack=%b%b, expected master %0d", ack1, ack0, e.idx);
            end
         end
      end
      compared++;
      if (ld_cnt !== 1) begin
         mismatched++;
         $display("[TB] FAIL write_ld_pulses: got %0d, expected 1", ld_cnt);
      end
      // ack after two edges = third cycle counting the IDLE request cycle
      compared++;
      if (ack_at !== 2) begin
         mismatched++;
         $display("[TB] FAIL write_latency: ack after %0d edges, expected 2", ack_at);
      end
      compared++;
      if (gnt1_seen !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL write_gnt1: got %b, expected 0", gnt1_seen);
      end
   endtask

   task automatic test_read();
      int   oe_cnt = 0;
      int   ack_at = -1;
      exp_t e;
      t_dout = 32'hDEAD_BEEF;
      sb.push_back('{1'b1, 1'b0, 32'hDEAD_BEEF});
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (t_oe) begin
            oe_cnt++;
            compared++;
            if (t_addr !== 3'd5) begin
               mismatched++;
               $display("[TB] FAIL read_addr: got %0d, expected 5", t_addr);
            end
         end
         if ((ack0 || ack1) && ack_at < 0) begin
            ack_at = c;
            req1 = 1'b0;
            e = sb.pop_front();
            compared++;
            if ({ack1, ack0, rdata} !== {(e.idx ? 2'b10 : 2'b01), e.rdata}) begin
               mismatched++;
               $display("[TB] FAIL read_ack: got ack=%b%b rdata=%h, expected master %0d rdata=%h",
                        ack1, ack0, rdata, e.idx, e.rdata);
            end
            t_dout = 32'h0123_4567;
         end
      end
      compared++;
      if (oe_cnt !== 2) begin
         mismatched++;
         $display("[TB] FAIL read_oe_cycles: got %0d, expected 2", oe_cnt);
      end
      compared++;
      if (ack_at !== 3) begin
         mismatched++;
         $display("[TB] FAIL read_latency: ack after %0d edges, expected 3", ack_at);
      end
      compared++;
      if (rdata !== 32'hDEAD_BEEF) begin
         mismatched++;
         $display("[TB] FAIL read_hold: got %h, expected deadbeef", rdata);
      end
   endtask

   task automatic test_contention();
      int   acks = 0;
      logic prev_ack = 1'b0;
      logic ptr_m = 1'b0;
      exp_t e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{ptr_m, 1'b1, 32'h0});
         ptr_m = ~ptr_m;
      end
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 32'hA0A0_A0A0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 3'd6; wdata1 = 32'hB1B1_B1B1;
      for (int c = 0; c < 40 && acks < 4; c++) begin
         tick();
         compared++;
         if ((gnt0 & gnt1) !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL contention_gnt_overlap: got gnt=%b%b, expected one-hot or zero", gnt1, gnt0);
         end
         if (prev_ack) begin
            compared++;
            if (busy !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL contention_idle_after_ack: got busy=%b, expected 0", busy);
            end
         end
         if (t_ld && sb.size() > 0) begin
            compared++;
            if (t_din !== (sb[0].idx ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0)) begin
               mismatched++;
               $display("[TB] FAIL contention_din: got %h, expected data of master %0d", t_din, sb[0].idx);
            end
         end
         if ((ack0 || ack1) && sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if ({ack1, ack0} !== (e.idx ? 2'b10 : 2'b01)) begin
               mismatched++;
               $display("[TB] FAIL contention_order: got ack=%b%b, expected master %0d", ack1, ack0, e.idx);
            end
            acks++;
            if (acks == 4) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
         prev_ack = ack0 | ack1;
      end
      compared++;
      if (acks !== 4) begin
         mismatched++;
         $display("[TB] FAIL contention_ack_count: got %0d, expected 4", acks);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_post_ack_mask();
      logic done = 1'b0;
      exp_t e;
      sb.push_back('{1'b0, 1'b1, 32'h0});
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 32'h5555_5555;
      for (int c = 1; c <= 8 && !done; c++) begin
         tick();
         if (ack0 || ack1) begin
            done = 1'b1;
            e = sb.pop_front();
            compared++;
            if ({ack1, ack0} !== 2'b01) begin
               mismatched++;
               $display("[TB] FAIL mask_first_ack: got ack=%b%b, expected 01", ack1, ack0);
            end
         end
      end
      // req0 deliberately left high through the masked IDLE cycle
      tick();
      tick();
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mask_ignored_cycle: got busy=%b, expected 0", busy);
      end
      sb.push_back('{1'b0, 1'b1, 32'h0});
      tick();
      compared++;
      if ({gnt1, gnt0} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL mask_new_request: got gnt=%b%b, expected 01", gnt1, gnt0);
      end
      done = 1'b0;
      for (int c = 1; c <= 8 && !done; c++) begin
         tick();
         if (ack0 || ack1) begin
            done = 1'b1;
            req0 = 1'b0;
            e = sb.pop_front();
            compared++;
            if ({ack1, ack0} !== 2'b01) begin
               mismatched++;
               $display("[TB] FAIL mask_second_ack: got ack=%b%b, expected 01", ack1, ack0);
            end
         end
      end
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mask_second_timeout: got done=%b, expected 1", done);
      end
      req0 = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_rd_lat3();
      logic [11:0] oe_trace = '0;
      int          ack_at = -1;
      exp_t        e;
      // t_dout changes every cycle; the last WAIT cycle is the one after edge 1+RD3
      t_dout_b = 32'h1000_0000;
      sb.push_back('{1'b0, 1'b0, 32'h1000_0000 + 32'(1 + RD3)});
      req0_b = 1'b1; we0_b = 1'b0; addr0_b = 3'd4;
      for (int c = 1; c <= 11; c++) begin
         tick();
         oe_trace[c] = t_oe_b;
         if ((ack0_b || ack1_b) && ack_at < 0) begin
            ack_at = c;
            req0_b = 1'b0;
            e = sb.pop_front();
            compared++;
            if ({ack1_b, ack0_b, rdata_b} !== {2'b01, e.rdata}) begin
               mismatched++;
               $display("[TB] FAIL rd3_capture: got ack=%b%b rdata=%h, expected 01 rdata=%h",
                        ack1_b, ack0_b, rdata_b, e.rdata);
            end
         end
         t_dout_b = 32'h1000_0000 + 32'(c);
      end
      compared++;
      if (oe_trace !== 12'b0000_0001_1110) begin
         mismatched++;
         $display("[TB] FAIL rd3_oe_window: got %b, expected 000000011110", oe_trace);
      end
      compared++;
      if (ack_at !== 2 + RD3) begin
         mismatched++;
         $display("[TB] FAIL rd3_latency: ack after %0d edges, expected %0d", ack_at, 2 + RD3);
      end
   endtask

   task automatic test_reset_abort();
      logic stray = 1'b0;
      logic done = 1'b0;
      exp_t e;
      t_dout = 32'h0000_1234;
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd7;
      tick();
      tick();
      compared++;
      if ({busy, gnt1, t_oe} !== 3'b111) begin
         mismatched++;
         $display("[TB] FAIL abort_in_wait: got busy=%b gnt1=%b oe=%b, expected 111", busy, gnt1, t_oe);
      end
      #2;
      rst = 1'b1;
      #1;
      compared++;
      if ({busy, gnt0, gnt1, ack0, ack1, t_ld, t_oe, t_addr, t_din, rdata} !== '0) begin
         mismatched++;
         $display("[TB] FAIL abort_async_clear: got busy=%b gnt=%b%b oe=%b rdata=%h, expected all 0",
                  busy, gnt1, gnt0, t_oe, rdata);
      end
      req1 = 1'b0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         stray |= ack0 | ack1 | t_ld | busy;
      end
      compared++;
      if (stray !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_no_ack: got activity=%b, expected 0", stray);
      end
      sb.push_back('{1'b0, 1'b1, 32'h0});
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = 32'h0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 3'd0; wdata1 = 32'h0;
      tick();
      compared++;
      if ({gnt1, gnt0} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL abort_pointer: got gnt=%b%b, expected 01", gnt1, gnt0);
      end
      for (int c = 1; c <= 8 && !done; c++) begin
         tick();
         if (ack0 || ack1) begin
            done = 1'b1;
            req0 = 1'b0;
            req1 = 1'b0;
            e = sb.pop_front();
            compared++;
            if ({ack1, ack0} !== (e.idx ? 2'b10 : 2'b01)) begin
               mismatched++;
               $display("[TB] FAIL abort_next_ack: got ack=%b%b, expected master %0d", ack1, ack0, e.idx);
            end
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      t_dout = '0;
      req0_b = 1'b0; we0_b = 1'b0; addr0_b = '0; wdata0_b = '0;
      req1_b = 1'b0; we1_b = 1'b0; addr1_b = '0; wdata1_b = '0;
      t_dout_b = '0;
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_post_ack_mask();
      test_rd_lat3();
      test_reset_abort();
      compared++;
      if (sb.size() !== 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
